// File: rtl/fifo_mwmr.sv
// fifo_mwmr: in-order FIFO with W_CNT write ports and R_CNT read ports per cycle,
// built on a single circular buffer of DEPTH entries.
//
// Ports:
//   i_clk, i_rst       clock and synchronous active-high reset
//   i_w_e, i_w_data    write enables (leading-ones prefix counts) and write data
//   o_w_ack, o_w_avail per-port write accepted; at least W_CNT free slots
//   i_r_e              read enables (leading-ones prefix counts)
//   o_r_data/_valid    k-th oldest entry and its validity; data is 0 when not valid
//   o_r_ack, o_r_avail per-port read consumed; at least R_CNT entries held
//   i_squash_e/_cnt    drop up to i_squash_cnt youngest entries (writes blocked)
//   i_flush            empty the queue next cycle (all acks blocked)
//   o_count, o_free    registered occupancy and DEPTH - occupancy
//   o_full, o_empty, o_almost_full  occupancy flags
//
// All outputs are combinational from registered state and current inputs; a
// written entry becomes readable on the following cycle (no bypass).
module fifo_mwmr #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 16,
  parameter int W_CNT       = 4,
  parameter int R_CNT       = 2,
  parameter int ALWAYS_READ = 0,
  parameter int AF_THRESH   = DEPTH - W_CNT
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [W_CNT-1:0]           i_w_e,
  input  logic [WIDTH-1:0]           i_w_data [0:W_CNT-1],
  output logic [W_CNT-1:0]           o_w_ack,
  output logic                       o_w_avail,
  input  logic [R_CNT-1:0]           i_r_e,
  output logic [WIDTH-1:0]           o_r_data [0:R_CNT-1],
  output logic [R_CNT-1:0]           o_r_valid,
  output logic [R_CNT-1:0]           o_r_ack,
  output logic                       o_r_avail,
  input  logic                       i_squash_e,
  input  logic [$clog2(DEPTH+1)-1:0] i_squash_cnt,
  input  logic                       i_flush,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic [$clog2(DEPTH+1)-1:0] o_free,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_almost_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  logic [PW-1:0]    head_reg, head_next;
  logic [PW-1:0]    tail_reg, tail_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [CW-1:0]    free;
  logic [CW-1:0]    nw, nr, squash_eff, remain;
  logic [W_CNT-1:0] wprefix;
  logic [R_CNT-1:0] rprefix;
  logic [R_CNT-1:0] r_live;
  logic             w_run, r_run;

  assign free = CW'(DEPTH) - count_reg;

  // Only the run of ones starting at bit 0 is a request; anything after the
  // first zero is ignored so acceptance is always in port order.
  always_comb begin
    wprefix = '0;
    w_run   = 1'b1;
    for (int k = 0; k < W_CNT; k++) begin
      w_run      = w_run & i_w_e[k];
      wprefix[k] = w_run;
    end
    rprefix = '0;
    r_run   = 1'b1;
    for (int k = 0; k < R_CNT; k++) begin
      r_run      = r_run & i_r_e[k];
      rprefix[k] = r_run;
    end
  end

  // Write port gi succeeds when it is requested and fits in the start-of-cycle
  // free space; same-cycle reads never create room.
  generate
    for (genvar gi = 0; gi < W_CNT; gi++) begin : g_wr
      assign o_w_ack[gi] = wprefix[gi] & (CW'(gi) < free) & ~i_squash_e & ~i_flush;
    end
  endgenerate

  // Read port gi shows the gi-th oldest entry.
  generate
    for (genvar gi = 0; gi < R_CNT; gi++) begin : g_rd
      logic [PW-1:0] rd_idx;
      assign rd_idx        = head_reg + PW'(gi);
      assign r_live[gi]    = CW'(gi) < count_reg;
      assign o_r_valid[gi] = r_live[gi] & ((ALWAYS_READ != 0) | rprefix[gi]);
      assign o_r_ack[gi]   = rprefix[gi] & r_live[gi] & ~i_flush;
      assign o_r_data[gi]  = o_r_valid[gi] ? mem[rd_idx] : '0;
    end
  endgenerate

  always_comb begin
    nw = '0;
    for (int k = 0; k < W_CNT; k++) nw = nw + CW'(o_w_ack[k]);
    nr = '0;
    for (int k = 0; k < R_CNT; k++) nr = nr + CW'(o_r_ack[k]);
  end

  // Squash removes from the young end after this cycle's reads; it is clamped
  // to what remains so the count can never underflow.
  always_comb begin
    remain     = count_reg - nr;
    squash_eff = '0;
    head_next  = head_reg + nr[PW-1:0];
    tail_next  = tail_reg + nw[PW-1:0];
    count_next = count_reg + nw - nr;
    if (i_squash_e) begin
      squash_eff = (i_squash_cnt < remain) ? i_squash_cnt : remain;
      tail_next  = tail_reg - squash_eff[PW-1:0];
      count_next = remain - squash_eff;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage is not reset; acks are already blocked under squash and flush.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < W_CNT; k++) begin
      if (o_w_ack[k]) mem[tail_reg + PW'(k)] <= i_w_data[k];
    end
  end

  assign o_count       = count_reg;
  assign o_free        = free;
  assign o_full        = (count_reg == CW'(DEPTH));
  assign o_empty       = (count_reg == '0);
  assign o_almost_full = (int'(count_reg) >= AF_THRESH);
  assign o_w_avail     = (int'(free) >= W_CNT);
  assign o_r_avail     = (int'(count_reg) >= R_CNT);

  a_count_bound: assert property (@(posedge i_clk) disable iff (i_rst)
    count_reg <= CW'(DEPTH));
  a_ptr_count: assert property (@(posedge i_clk) disable iff (i_rst)
    PW'(tail_reg - head_reg) == count_reg[PW-1:0]);
  a_wack_prefix: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_w_ack & (o_w_ack + W_CNT'(1))) == '0);
  a_rack_prefix: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_r_ack & (o_r_ack + R_CNT'(1))) == '0);

endmodule

// File: tb/tb_fifo_mwmr.sv
// tb_fifo_mwmr: randomized and directed checks of fifo_mwmr against a queue
// model that tracks FIFO contents directly.
module tb_fifo_mwmr;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int W_CNT = 4;
  localparam int R_CNT = 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AF    = DEPTH - W_CNT;

  logic             clk = 1'b0;
  logic             rst;
  logic [W_CNT-1:0] w_e;
  logic [WIDTH-1:0] w_data [0:W_CNT-1];
  logic [W_CNT-1:0] w_ack;
  logic             w_avail;
  logic [R_CNT-1:0] r_e;
  logic [WIDTH-1:0] r_data [0:R_CNT-1];
  logic [R_CNT-1:0] r_valid, r_ack;
  logic             r_avail;
  logic             squash_e;
  logic [CW-1:0]    squash_cnt;
  logic             flush;
  logic [CW-1:0]    count, free;
  logic             full, empty, almost_full;

  always #5 clk = ~clk;

  fifo_mwmr #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .W_CNT(W_CNT), .R_CNT(R_CNT),
    .ALWAYS_READ(0), .AF_THRESH(AF)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_w_e(w_e), .i_w_data(w_data), .o_w_ack(w_ack), .o_w_avail(w_avail),
    .i_r_e(r_e), .o_r_data(r_data), .o_r_valid(r_valid), .o_r_ack(r_ack),
    .o_r_avail(r_avail),
    .i_squash_e(squash_e), .i_squash_cnt(squash_cnt), .i_flush(flush),
    .o_count(count), .o_free(free), .o_full(full), .o_empty(empty),
    .o_almost_full(almost_full)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] stim [0:W_CNT-1];
  logic [W_CNT-1:0] last_wack;
  logic [R_CNT-1:0] last_rack;
  logic [WIDTH-1:0] last_rdata [0:R_CNT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lead_ones(input logic [7:0] v, input int n);
    int c = 0;
    for (int k = 0; k < n; k++) begin
      if (!v[k]) break;
      c++;
    end
    return c;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic rand_stim();
    for (int k = 0; k < W_CNT; k++) stim[k] = $urandom;
  endtask

  // One clock: drive at the falling edge, compare 1ns later, advance the model
  // to what the rising edge must produce.
  task automatic cycle(input logic [W_CNT-1:0] we, input logic [R_CNT-1:0] re,
                       input logic sq_e, input logic [CW-1:0] sq_cnt,
                       input logic fl, input logic rs);
    int cnt, wp, rp, nw, nr, nv, eff;
    logic [W_CNT-1:0] wmask;
    logic [R_CNT-1:0] rmask, vmask;
    logic [WIDTH-1:0] exp_d;
    w_e = we; r_e = re; squash_e = sq_e; squash_cnt = sq_cnt; flush = fl; rst = rs;
    for (int k = 0; k < W_CNT; k++) w_data[k] = stim[k];
    #1;
    cnt = q.size();
    wp  = lead_ones(8'(we), W_CNT);
    rp  = lead_ones(8'(re), R_CNT);
    nw  = (fl || sq_e) ? 0 : imin(wp, DEPTH - cnt);
    nv  = imin(rp, cnt);
    nr  = fl ? 0 : nv;
    for (int k = 0; k < W_CNT; k++) wmask[k] = (k < nw);
    for (int k = 0; k < R_CNT; k++) begin
      rmask[k] = (k < nr);
      vmask[k] = (k < nv);
    end
    last_wack = w_ack;
    last_rack = r_ack;
    for (int k = 0; k < R_CNT; k++) last_rdata[k] = r_data[k];
    if (!rs) begin
      chk("w_ack", 64'(w_ack), 64'(wmask));
      chk("r_ack", 64'(r_ack), 64'(rmask));
      chk("r_valid", 64'(r_valid), 64'(vmask));
      for (int k = 0; k < R_CNT; k++) begin
        exp_d = vmask[k] ? q[k] : '0;
        chk($sformatf("r_data%0d", k), 64'(r_data[k]), 64'(exp_d));
      end
      chk("count", 64'(count), 64'(cnt));
      chk("free", 64'(free), 64'(DEPTH - cnt));
      chk("flags", {61'd0, full, empty, almost_full},
          {61'd0, cnt == DEPTH, cnt == 0, cnt >= AF});
      chk("avail", {62'd0, w_avail, r_avail},
          {62'd0, (DEPTH - cnt) >= W_CNT, cnt >= R_CNT});
    end
    if (rs || fl) begin
      q.delete();
    end else begin
      repeat (nr) void'(q.pop_front());
      if (sq_e) begin
        eff = imin(int'(sq_cnt), q.size());
        repeat (eff) void'(q.pop_back());
      end else begin
        for (int k = 0; k < nw; k++) q.push_back(stim[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [W_CNT-1:0] we);
    cycle(we, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [R_CNT-1:0] re);
    cycle('0, re, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_free"}, 64'(free), 64'd16);
    chk({tag, "_flags"}, {60'd0, empty, full, w_avail, r_avail}, {60'd0, 4'b1010});
    chk({tag, "_af"}, 64'(almost_full), 64'd0);
  endtask

  initial begin
    for (int k = 0; k < W_CNT; k++) stim[k] = '0;
    rand_stim();
    cycle('0, '0, 1'b0, '0, 1'b0, 1'b1);
    cycle('0, '0, 1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    chk_reset_state("por");

    // Fill at 4 per cycle.
    for (int i = 0; i < 4; i++) begin
      if (i == 2) chk("lit_af_at8", 64'(almost_full), 64'd0);
      if (i == 3) chk("lit_af_at12", 64'(almost_full), 64'd1);
      rand_stim();
      wr(4'b1111);
      chk("lit_fill_ack", 64'(last_wack), 64'hf);
    end
    chk("lit_full", {61'd0, full, w_avail, empty}, {61'd0, 3'b100});
    chk("lit_count16", 64'(count), 64'd16);

    // Partial acceptance limited by free space.
    rd(2'b01);
    rd(2'b01);
    rand_stim();
    wr(4'b1111);
    chk("lit_partial_ack", 64'(last_wack), 64'h3);
    chk("lit_partial_cnt", 64'(count), 64'd16);

    // Flush at count 8 with everything requested.
    for (int i = 0; i < 4; i++) rd(2'b11);
    chk("lit_cnt8", 64'(count), 64'd8);
    cycle(4'b1111, 2'b11, 1'b0, '0, 1'b1, 1'b0);
    chk("lit_flush_acks", {58'd0, last_wack, last_rack}, 64'd0);
    chk("lit_flush_empty", {62'd0, empty, 1'b0}, {62'd0, 2'b10});

    // Prefix rule: 1011 only counts as two.
    rand_stim();
    wr(4'b1011);
    chk("lit_prefix_ack", 64'(last_wack), 64'h3);
    rd(2'b11);

    // Over-asking reads at count 1.
    rand_stim();
    wr(4'b0001);
    rd(2'b11);
    chk("lit_rack_short", 64'(last_rack), 64'h1);
    chk("lit_rdata1_zero", 64'(last_rdata[1]), 64'd0);

    // Wrap: head is now 3; move both pointers to 14, then stream A..E across 15->0.
    rand_stim(); wr(4'b1111);
    rand_stim(); wr(4'b1111);
    rand_stim(); wr(4'b0111);
    for (int i = 0; i < 5; i++) rd(2'b11);
    rd(2'b01);
    stim[0] = 32'hA; stim[1] = 32'hB; stim[2] = 32'hC; stim[3] = 32'hD;
    wr(4'b1111);
    stim[0] = 32'hE;
    wr(4'b0001);
    rd(2'b11);
    chk("lit_wrap_ab", {last_rdata[0], last_rdata[1]}, {32'hA, 32'hB});
    rd(2'b11);
    chk("lit_wrap_cd", {last_rdata[0], last_rdata[1]}, {32'hC, 32'hD});
    rd(2'b11);
    chk("lit_wrap_e", {30'd0, last_rack, last_rdata[0]}, {30'd0, 2'b01, 32'hE});

    // Squash with concurrent reads and writes.
    for (int k = 0; k < W_CNT; k++) stim[k] = 32'h100 + 32'(k);
    wr(4'b1111);
    stim[0] = 32'h104; stim[1] = 32'h105;
    wr(4'b0011);
    rand_stim();
    cycle(4'b1111, 2'b11, 1'b1, CW'(3), 1'b0, 1'b0);
    chk("lit_squash_wack", 64'(last_wack), 64'd0);
    chk("lit_squash_cnt", 64'(count), 64'd1);
    rd(2'b01);
    chk("lit_squash_survivor", 64'(last_rdata[0]), 64'h102);

    // Oversized squash clamps to empty.
    rand_stim(); wr(4'b1111);
    rand_stim(); wr(4'b0001);
    cycle('0, '0, 1'b1, CW'(15), 1'b0, 1'b0);
    chk("lit_squash_clamp", 64'(count), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int p;
      logic sq, fl, rs;
      p  = int'($urandom_range(0, 99));
      sq = (p < 6);
      fl = (p >= 6 && p < 8);
      rs = (p == 8);
      rand_stim();
      cycle(W_CNT'($urandom), R_CNT'($urandom), sq, CW'($urandom_range(0, DEPTH)), fl, rs);
    end

    // Reset in the middle of traffic.
    rand_stim(); wr(4'b1111);
    rand_stim(); cycle(4'b1111, 2'b11, 1'b0, '0, 1'b0, 1'b0);
    rand_stim(); cycle(4'b1111, 2'b11, 1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0;
    chk_reset_state("mid_rst");
    rand_stim(); wr(4'b0011);
    rd(2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
